// File: rtl/regf_burst_engine_if.sv
// Bundle of command, register-file, TX/RX stream and status signals for the burst engine.
// Latency: none, wiring only.
// Backpressure: carries tx_valid/tx_ready and rx_valid/rx_ready; the engine side is the slave modport.
interface regf_burst_engine_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 10
);
  // command
  logic             i_rfa_start;
  logic             i_rfa_dir;
  logic             i_rfa_abort;
  logic [ADDR-1:0]  i_rfa_base_addr;
  logic [WIDTH-1:0] i_rfa_len;
  // register file
  logic             o_rfa_regf_rd_en;
  logic             o_rfa_regf_wr_en;
  logic [ADDR-1:0]  o_rfa_regf_addr;
  logic [WIDTH-1:0] o_rfa_regf_data_wr;
  logic [WIDTH-1:0] i_rfa_regf_data_rd;
  // TX stream
  logic [WIDTH-1:0] o_rfa_tx_data;
  logic             o_rfa_tx_valid;
  logic             i_rfa_tx_ready;
  // RX stream
  logic [WIDTH-1:0] i_rfa_rx_data;
  logic             i_rfa_rx_valid;
  logic             o_rfa_rx_ready;
  // status
  logic             o_rfa_busy;
  logic             o_rfa_done;
  logic             o_rfa_abort_ack;
  logic [WIDTH-1:0] o_rfa_count;

  // Controller / environment side
  modport master (
    output i_rfa_start, i_rfa_dir, i_rfa_abort, i_rfa_base_addr, i_rfa_len,
    output i_rfa_regf_data_rd, i_rfa_tx_ready, i_rfa_rx_data, i_rfa_rx_valid,
    input  o_rfa_regf_rd_en, o_rfa_regf_wr_en, o_rfa_regf_addr, o_rfa_regf_data_wr,
    input  o_rfa_tx_data, o_rfa_tx_valid, o_rfa_rx_ready,
    input  o_rfa_busy, o_rfa_done, o_rfa_abort_ack, o_rfa_count
  );

  // Burst engine side
  modport slave (
    input  i_rfa_start, i_rfa_dir, i_rfa_abort, i_rfa_base_addr, i_rfa_len,
    input  i_rfa_regf_data_rd, i_rfa_tx_ready, i_rfa_rx_data, i_rfa_rx_valid,
    output o_rfa_regf_rd_en, o_rfa_regf_wr_en, o_rfa_regf_addr, o_rfa_regf_data_wr,
    output o_rfa_tx_data, o_rfa_tx_valid, o_rfa_rx_ready,
    output o_rfa_busy, o_rfa_done, o_rfa_abort_ack, o_rfa_count
  );
endinterface

// File: rtl/regf_burst_engine.sv
// Burst engine: streams a length-prefixed regfile block out on TX, or writes a fixed-length RX stream into the regfile.
// Latency: 3 cycles per TX byte at full rate (read, wait, hold); an RX byte is written the cycle after its handshake.
// Backpressure: tx_valid/tx_data held until tx_ready; rx_ready is high only while waiting for the next RX byte.
module regf_burst_engine #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 10
) (
  input logic                i_rfa_clk,
  input logic                i_rfa_rst,
  regf_burst_engine_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_RD, LEN_WAIT, DATA_RD, DATA_WAIT, TX_HOLD, RX_WAIT, WR, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ADDR-1:0]  ptr_q, addr_hold_q, addr_d;
  logic [WIDTH-1:0] rem_q, cnt_q, tx_dat_q, rx_dat_q;
  logic             ack_q;
  logic             abort_take, tx_hs, rx_hs, rd_en, wr_en;

  // State register
  always_ff @(posedge i_rfa_clk) begin
    if (i_rfa_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state, handshake decode and regfile enables; abort masks enables in the cycle it is taken
  always_comb begin
    state_d    = state_q;
    abort_take = bus.i_rfa_abort && (state_q != IDLE) && (state_q != DONE);
    tx_hs      = (state_q == TX_HOLD) && bus.i_rfa_tx_ready;
    rx_hs      = (state_q == RX_WAIT) && bus.i_rfa_rx_valid;
    rd_en      = ((state_q == LEN_RD) || (state_q == DATA_RD)) && !abort_take;
    wr_en      = (state_q == WR) && !abort_take;
    // the pointer already holds base during LEN_RD, so one address source covers every access
    addr_d     = (rd_en || wr_en) ? ptr_q : addr_hold_q;
    case (state_q)
      IDLE: begin
        if (bus.i_rfa_start) begin
          if (bus.i_rfa_dir) state_d = (bus.i_rfa_len == '0) ? DONE : RX_WAIT;
          else               state_d = LEN_RD;
        end
      end
      LEN_RD:    state_d = LEN_WAIT;
      LEN_WAIT:  state_d = (bus.i_rfa_regf_data_rd == '0) ? DONE : DATA_RD;
      DATA_RD:   state_d = DATA_WAIT;
      DATA_WAIT: state_d = TX_HOLD;
      TX_HOLD: begin
        if (tx_hs) state_d = (rem_q == WIDTH'(1)) ? DONE : DATA_RD;
      end
      RX_WAIT: begin
        if (rx_hs) state_d = WR;
      end
      WR:        state_d = (rem_q == WIDTH'(1)) ? DONE : RX_WAIT;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort_take) state_d = IDLE;
  end

  // Datapath: pointer, remaining, count, captured bytes, address hold and abort acknowledge
  always_ff @(posedge i_rfa_clk) begin
    if (i_rfa_rst) begin
      ptr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      tx_dat_q    <= '0;
      rx_dat_q    <= '0;
      addr_hold_q <= '0;
      ack_q       <= 1'b0;
    end else begin
      ack_q       <= abort_take;
      addr_hold_q <= addr_d;
      case (state_q)
        IDLE: begin
          if (bus.i_rfa_start) begin
            ptr_q <= bus.i_rfa_base_addr;
            cnt_q <= '0;
            if (bus.i_rfa_dir) rem_q <= bus.i_rfa_len;
          end
        end
        LEN_WAIT: begin
          if (!abort_take) begin
            rem_q <= bus.i_rfa_regf_data_rd;
            ptr_q <= ptr_q + 1'b1;
          end
        end
        DATA_WAIT: begin
          if (!abort_take) tx_dat_q <= bus.i_rfa_regf_data_rd;
        end
        TX_HOLD: begin
          // a byte handed over on TX counts even if abort arrives in the same cycle
          if (tx_hs) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_q - 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_hs && !abort_take) rx_dat_q <= bus.i_rfa_rx_data;
        end
        WR: begin
          if (!abort_take) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_rfa_regf_rd_en   = rd_en;
  assign bus.o_rfa_regf_wr_en   = wr_en;
  assign bus.o_rfa_regf_addr    = addr_d;
  assign bus.o_rfa_regf_data_wr = rx_dat_q;
  assign bus.o_rfa_tx_data      = tx_dat_q;
  assign bus.o_rfa_tx_valid     = (state_q == TX_HOLD);
  assign bus.o_rfa_rx_ready     = (state_q == RX_WAIT);
  assign bus.o_rfa_busy         = (state_q != IDLE);
  assign bus.o_rfa_done         = (state_q == DONE);
  assign bus.o_rfa_abort_ack    = ack_q;
  assign bus.o_rfa_count        = cnt_q;

endmodule

// File: tb/tb_regf_burst_engine.sv
// Directed bench for the regfile burst engine with a 1-cycle-latency regfile model.
// Latency: n/a.
// Backpressure: TX ready and RX valid are driven per scenario.
module tb_regf_burst_engine;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  regf_burst_engine_if #(.WIDTH(8), .ADDR(10)) bus ();

  regf_burst_engine #(.WIDTH(8), .ADDR(10)) dut (
    .i_rfa_clk (clk),
    .i_rfa_rst (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // regfile model: synchronous write, 1-cycle read latency, plus a preload port
  logic [7:0] mem [0:1023];
  logic [7:0] rd_q;
  logic       pl_en;
  logic [9:0] pl_a;
  logic [7:0] pl_d;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (bus.o_rfa_regf_wr_en) mem[bus.o_rfa_regf_addr] <= bus.o_rfa_regf_data_wr;
    if (bus.o_rfa_regf_rd_en) rd_q <= mem[bus.o_rfa_regf_addr];
  end
  assign bus.i_rfa_regf_data_rd = rd_q;

  // event log, sampled on the falling edge
  logic [9:0] rd_log[$];
  logic [9:0] wr_a_log[$];
  logic [7:0] wr_d_log[$];
  logic [7:0] tx_log[$];
  int done_cnt, ack_cnt, excl_err;
  logic prev_rd, prev_wr;

  initial begin
    done_cnt = 0; ack_cnt = 0; excl_err = 0; prev_rd = 0; prev_wr = 0;
  end

  always @(negedge clk) begin
    if (bus.o_rfa_regf_rd_en) rd_log.push_back(bus.o_rfa_regf_addr);
    if (bus.o_rfa_regf_wr_en) begin
      wr_a_log.push_back(bus.o_rfa_regf_addr);
      wr_d_log.push_back(bus.o_rfa_regf_data_wr);
    end
    if (bus.o_rfa_tx_valid && bus.i_rfa_tx_ready) tx_log.push_back(bus.o_rfa_tx_data);
    if (bus.o_rfa_done) done_cnt++;
    if (bus.o_rfa_abort_ack) ack_cnt++;
    if (bus.o_rfa_regf_rd_en && bus.o_rfa_regf_wr_en) excl_err++;
    if ((bus.o_rfa_regf_rd_en && prev_rd) || (bus.o_rfa_regf_wr_en && prev_wr)) excl_err++;
    prev_rd = bus.o_rfa_regf_rd_en;
    prev_wr = bus.o_rfa_regf_wr_en;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log;
    rd_log.delete(); wr_a_log.delete(); wr_d_log.delete(); tx_log.delete();
    done_cnt = 0; ack_cnt = 0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic start(input logic dir, input logic [9:0] base, input logic [7:0] len);
    bus.i_rfa_start = 1'b1; bus.i_rfa_dir = dir; bus.i_rfa_base_addr = base; bus.i_rfa_len = len;
    tick;
    bus.i_rfa_start = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    logic hs;
    int   n;
    repeat (gap) tick;
    bus.i_rfa_rx_data = b; bus.i_rfa_rx_valid = 1'b1;
    n = 0;
    do begin
      hs = bus.o_rfa_rx_ready;
      tick;
      n++;
    end while (!hs && n < 50);
    bus.i_rfa_rx_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (bus.o_rfa_busy && n < 200) begin tick; n++; end
  endtask

  task automatic wait_tx_valid;
    int n;
    n = 0;
    while (!bus.o_rfa_tx_valid && n < 50) begin tick; n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_rfa_start = 1'b1; bus.i_rfa_abort = 1'b1;
    tick; tick;
    bus.i_rfa_start = 1'b0; bus.i_rfa_abort = 1'b0;
    tests++;
    if ({bus.o_rfa_busy, bus.o_rfa_done, bus.o_rfa_abort_ack} !== 3'b000) begin
      fails++; $display("FAIL reset_status: busy/done/ack=%b required 000", {bus.o_rfa_busy, bus.o_rfa_done, bus.o_rfa_abort_ack});
    end
    tests++;
    if ({bus.o_rfa_regf_rd_en, bus.o_rfa_regf_wr_en, bus.o_rfa_tx_valid, bus.o_rfa_rx_ready} !== 4'b0000) begin
      fails++; $display("FAIL reset_enables: rd/wr/txv/rxr=%b required 0000", {bus.o_rfa_regf_rd_en, bus.o_rfa_regf_wr_en, bus.o_rfa_tx_valid, bus.o_rfa_rx_ready});
    end
    tests++;
    if ({bus.o_rfa_regf_addr, bus.o_rfa_regf_data_wr, bus.o_rfa_tx_data, bus.o_rfa_count} !== 34'd0) begin
      fails++; $display("FAIL reset_data: addr=%0d wdat=%h txd=%h cnt=%0d required all 0", bus.o_rfa_regf_addr, bus.o_rfa_regf_data_wr, bus.o_rfa_tx_data, bus.o_rfa_count);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_read_burst;
    logic [9:0] exp_a [3];
    logic [7:0] exp_d [2];
    exp_a[0] = 10'd1; exp_a[1] = 10'd2; exp_a[2] = 10'd3;
    exp_d[0] = 8'h01; exp_d[1] = 8'h02;
    preload(10'd1, 8'd2); preload(10'd2, 8'h01); preload(10'd3, 8'h02);
    bus.i_rfa_tx_ready = 1'b1;
    clr_log;
    start(1'b0, 10'd1, 8'd0);
    wait_idle;
    tests++;
    if (bus.o_rfa_busy !== 1'b0) begin fails++; $display("FAIL rd_burst_timeout: busy=%b required 0", bus.o_rfa_busy); end
    tests++;
    if (rd_log.size() != 3) begin fails++; $display("FAIL rd_burst_nreads: got %0d required 3", rd_log.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++;
      if (rd_log[i] !== exp_a[i]) begin fails++; $display("FAIL rd_burst_addr[%0d]: got %0d required %0d", i, rd_log[i], exp_a[i]); end
    end
    tests++;
    if (tx_log.size() != 2) begin fails++; $display("FAIL rd_burst_ntx: got %0d required 2", tx_log.size()); end
    else for (int i = 0; i < 2; i++) begin
      tests++;
      if (tx_log[i] !== exp_d[i]) begin fails++; $display("FAIL rd_burst_tx[%0d]: got %h required %h", i, tx_log[i], exp_d[i]); end
    end
    tests++;
    if (done_cnt != 1 || ack_cnt != 0) begin fails++; $display("FAIL rd_burst_done: done=%0d ack=%0d required 1 0", done_cnt, ack_cnt); end
    tests++;
    if (bus.o_rfa_count !== 8'd2) begin fails++; $display("FAIL rd_burst_count: got %0d required 2", bus.o_rfa_count); end
  endtask

  task automatic test_backpressure;
    int nrd;
    preload(10'd10, 8'd1); preload(10'd11, 8'h5C);
    bus.i_rfa_tx_ready = 1'b0;
    clr_log;
    start(1'b0, 10'd10, 8'd0);
    wait_tx_valid;
    nrd = rd_log.size();
    for (int i = 0; i < 5; i++) begin
      // a start pulse while busy must be ignored
      if (i == 2) begin bus.i_rfa_start = 1'b1; bus.i_rfa_dir = 1'b1; bus.i_rfa_len = 8'd5; end
      tick;
      bus.i_rfa_start = 1'b0;
      tests++;
      if (bus.o_rfa_tx_valid !== 1'b1 || bus.o_rfa_tx_data !== 8'h5C) begin
        fails++; $display("FAIL bp_hold[%0d]: valid=%b data=%h required 1 5c", i, bus.o_rfa_tx_valid, bus.o_rfa_tx_data);
      end
    end
    tests++;
    if (rd_log.size() != nrd) begin fails++; $display("FAIL bp_no_rd: reads=%0d required %0d", rd_log.size(), nrd); end
    bus.i_rfa_tx_ready = 1'b1;
    wait_idle;
    tests++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h5C) begin fails++; $display("FAIL bp_tx: n=%0d required 1 byte 5c", tx_log.size()); end
    tests++;
    if (done_cnt != 1 || bus.o_rfa_count !== 8'd1 || wr_a_log.size() != 0) begin
      fails++; $display("FAIL bp_done: done=%0d cnt=%0d writes=%0d required 1 1 0", done_cnt, bus.o_rfa_count, wr_a_log.size());
    end
  endtask

  task automatic test_write_burst;
    logic [9:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a[0] = 10'd5; exp_a[1] = 10'd6; exp_a[2] = 10'd7;
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3;
    clr_log;
    start(1'b1, 10'd5, 8'd3);
    send_rx(8'hA1, 2); send_rx(8'hA2, 3); send_rx(8'hA3, 1);
    wait_idle;
    tests++;
    if (wr_a_log.size() != 3) begin fails++; $display("FAIL wr_burst_nwr: got %0d required 3", wr_a_log.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++;
      if (wr_a_log[i] !== exp_a[i] || wr_d_log[i] !== exp_d[i]) begin
        fails++; $display("FAIL wr_burst[%0d]: addr=%0d data=%h required %0d %h", i, wr_a_log[i], wr_d_log[i], exp_a[i], exp_d[i]);
      end
    end
    tests++;
    if (done_cnt != 1 || bus.o_rfa_count !== 8'd3 || rd_log.size() != 0) begin
      fails++; $display("FAIL wr_burst_done: done=%0d cnt=%0d reads=%0d required 1 3 0", done_cnt, bus.o_rfa_count, rd_log.size());
    end
  endtask

  task automatic test_wrap_zero;
    clr_log;
    start(1'b1, 10'd1023, 8'd2);
    send_rx(8'h11, 0); send_rx(8'h22, 1);
    wait_idle;
    tests++;
    if (wr_a_log.size() != 2) begin fails++; $display("FAIL wrap_nwr: got %0d required 2", wr_a_log.size()); end
    else begin
      tests++;
      if (wr_a_log[0] !== 10'd1023 || wr_a_log[1] !== 10'd0 || wr_d_log[1] !== 8'h22) begin
        fails++; $display("FAIL wrap_addr: got %0d,%0d data2=%h required 1023,0 22", wr_a_log[0], wr_a_log[1], wr_d_log[1]);
      end
    end
    tests++;
    if (done_cnt != 1 || bus.o_rfa_count !== 8'd2) begin fails++; $display("FAIL wrap_done: done=%0d cnt=%0d required 1 2", done_cnt, bus.o_rfa_count); end
    preload(10'd20, 8'd0);
    clr_log;
    start(1'b0, 10'd20, 8'd0);
    wait_idle;
    tests++;
    if (rd_log.size() != 1 || rd_log[0] !== 10'd20) begin fails++; $display("FAIL zero_rd: reads=%0d required 1 at 20", rd_log.size()); end
    tests++;
    if (done_cnt != 1 || bus.o_rfa_count !== 8'd0 || tx_log.size() != 0) begin
      fails++; $display("FAIL zero_done: done=%0d cnt=%0d tx=%0d required 1 0 0", done_cnt, bus.o_rfa_count, tx_log.size());
    end
    clr_log;
    start(1'b1, 10'd30, 8'd0);
    wait_idle;
    tests++;
    if (done_cnt != 1 || wr_a_log.size() != 0) begin fails++; $display("FAIL zero_wr: done=%0d writes=%0d required 1 0", done_cnt, wr_a_log.size()); end
  endtask

  task automatic test_abort;
    int n;
    // abort in IDLE has no effect
    clr_log;
    bus.i_rfa_abort = 1'b1; tick; bus.i_rfa_abort = 1'b0; tick;
    tests++;
    if (ack_cnt != 0 || bus.o_rfa_busy !== 1'b0) begin fails++; $display("FAIL abort_idle: ack=%0d busy=%b required 0 0", ack_cnt, bus.o_rfa_busy); end
    // abort coincident with the third RX handshake
    clr_log;
    start(1'b1, 10'd40, 8'd4);
    send_rx(8'hB1, 1); send_rx(8'hB2, 1);
    n = 0;
    while (!bus.o_rfa_rx_ready && n < 20) begin tick; n++; end
    bus.i_rfa_rx_data = 8'hB3; bus.i_rfa_rx_valid = 1'b1; bus.i_rfa_abort = 1'b1;
    tick;
    bus.i_rfa_rx_valid = 1'b0; bus.i_rfa_abort = 1'b0;
    tests++;
    if (bus.o_rfa_abort_ack !== 1'b1 || bus.o_rfa_busy !== 1'b0) begin
      fails++; $display("FAIL abort_rx_state: ack=%b busy=%b required 1 0", bus.o_rfa_abort_ack, bus.o_rfa_busy);
    end
    tick; tick;
    tests++;
    if (wr_a_log.size() != 2 || done_cnt != 0 || ack_cnt != 1) begin
      fails++; $display("FAIL abort_rx_log: writes=%0d done=%0d ack=%0d required 2 0 1", wr_a_log.size(), done_cnt, ack_cnt);
    end
    tests++;
    if (bus.o_rfa_count !== 8'd2) begin fails++; $display("FAIL abort_rx_count: got %0d required 2", bus.o_rfa_count); end
    // abort landing on the WR cycle suppresses the write
    clr_log;
    start(1'b1, 10'd60, 8'd3);
    send_rx(8'hC1, 0);
    bus.i_rfa_abort = 1'b1;
    tick;
    bus.i_rfa_abort = 1'b0;
    tick;
    tests++;
    if (wr_a_log.size() != 0 || ack_cnt != 1 || bus.o_rfa_count !== 8'd0) begin
      fails++; $display("FAIL abort_wr: writes=%0d ack=%0d cnt=%0d required 0 1 0", wr_a_log.size(), ack_cnt, bus.o_rfa_count);
    end
    // abort coincident with a TX handshake still counts the byte
    preload(10'd80, 8'd2); preload(10'd81, 8'h33); preload(10'd82, 8'h44);
    bus.i_rfa_tx_ready = 1'b0;
    clr_log;
    start(1'b0, 10'd80, 8'd0);
    wait_tx_valid;
    bus.i_rfa_tx_ready = 1'b1; bus.i_rfa_abort = 1'b1;
    tick;
    bus.i_rfa_abort = 1'b0;
    tick;
    tests++;
    if (tx_log.size() != 1 || bus.o_rfa_count !== 8'd1 || ack_cnt != 1 || done_cnt != 0 || bus.o_rfa_busy !== 1'b0) begin
      fails++; $display("FAIL abort_tx: tx=%0d cnt=%0d ack=%0d done=%0d busy=%b required 1 1 1 0 0", tx_log.size(), bus.o_rfa_count, ack_cnt, done_cnt, bus.o_rfa_busy);
    end
  endtask

  task automatic test_reset_mid;
    preload(10'd90, 8'd1); preload(10'd91, 8'h77);
    bus.i_rfa_tx_ready = 1'b0;
    clr_log;
    start(1'b0, 10'd90, 8'd0);
    wait_tx_valid;
    rst = 1'b1;
    tick;
    tests++;
    if ({bus.o_rfa_tx_valid, bus.o_rfa_busy, bus.o_rfa_regf_rd_en, bus.o_rfa_done, bus.o_rfa_abort_ack} !== 5'd0 ||
        bus.o_rfa_tx_data !== 8'd0 || bus.o_rfa_regf_addr !== 10'd0 || bus.o_rfa_count !== 8'd0) begin
      fails++; $display("FAIL rst_mid_outputs: txv=%b busy=%b txd=%h addr=%0d cnt=%0d required all 0",
                        bus.o_rfa_tx_valid, bus.o_rfa_busy, bus.o_rfa_tx_data, bus.o_rfa_regf_addr, bus.o_rfa_count);
    end
    rst = 1'b0;
    tick;
    tests++;
    if (done_cnt != 0 || ack_cnt != 0) begin fails++; $display("FAIL rst_mid_pulses: done=%0d ack=%0d required 0 0", done_cnt, ack_cnt); end
    bus.i_rfa_tx_ready = 1'b1;
    clr_log;
    start(1'b0, 10'd90, 8'd0);
    wait_idle;
    tests++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h77 || done_cnt != 1 || bus.o_rfa_count !== 8'd1) begin
      fails++; $display("FAIL rst_mid_restart: tx=%0d done=%0d cnt=%0d required 1 byte 77, 1, 1", tx_log.size(), done_cnt, bus.o_rfa_count);
    end
  endtask

  task automatic test_enable_rules;
    tests++;
    if (excl_err != 0) begin fails++; $display("FAIL enable_rules: violations=%0d required 0", excl_err); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    bus.i_rfa_start = 1'b0; bus.i_rfa_dir = 1'b0; bus.i_rfa_abort = 1'b0;
    bus.i_rfa_base_addr = '0; bus.i_rfa_len = '0;
    bus.i_rfa_tx_ready = 1'b0; bus.i_rfa_rx_data = '0; bus.i_rfa_rx_valid = 1'b0;
    test_reset;
    test_read_burst;
    test_backpressure;
    test_write_burst;
    test_wrap_zero;
    test_abort;
    test_reset_mid;
    test_enable_rules;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regf_burst_engine.md
REGF_BURST_ENGINE -- requirements
Module: regf_burst_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 The block SHALL have parameter ADDR, default 10, register-file address width.
REQ-003 The block SHALL have ports i_rfa_clk in 1 (the single clock) and i_rfa_rst in 1 (reset, synchronous, active-high).
REQ-004 The block SHALL have ports i_rfa_start in 1 (start pulse), i_rfa_dir in 1 (0 = read/TX, 1 = write/RX), i_rfa_abort in 1 (abort pulse).
REQ-005 The block SHALL have ports i_rfa_base_addr in ADDR (first address) and i_rfa_len in WIDTH (write byte count).
REQ-006 The block SHALL have register-file ports o_rfa_regf_rd_en out 1, o_rfa_regf_wr_en out 1, o_rfa_regf_addr out ADDR, o_rfa_regf_data_wr out WIDTH and i_rfa_regf_data_rd in WIDTH.
REQ-007 The block SHALL have TX stream ports o_rfa_tx_data out WIDTH, o_rfa_tx_valid out 1 and i_rfa_tx_ready in 1.
REQ-008 The block SHALL have RX stream ports i_rfa_rx_data in WIDTH, i_rfa_rx_valid in 1 and o_rfa_rx_ready out 1.
REQ-009 The block SHALL have status ports o_rfa_busy out 1, o_rfa_done out 1 (pulse), o_rfa_abort_ack out 1 (pulse) and o_rfa_count out WIDTH (bytes moved in current or last burst).

Function
REQ-010 The FSM SHALL use states IDLE, LEN_RD, LEN_WAIT, DATA_RD, DATA_WAIT, TX_HOLD, RX_WAIT, WR and DONE.
REQ-011 In IDLE with i_rfa_start=1 and i_rfa_dir=0, the block SHALL latch base, clear o_rfa_count and go to LEN_RD.
REQ-012 In IDLE with i_rfa_start=1 and i_rfa_dir=1, the block SHALL latch base, latch i_rfa_len and clear count, then go to DONE if len=0, else RX_WAIT.
REQ-013 LEN_RD SHALL assert rd_en for exactly 1 cycle with addr = base, then go to LEN_WAIT (register-file read latency is 1 cycle).
REQ-014 LEN_WAIT SHALL capture i_rfa_regf_data_rd as remaining length and set pointer = base+1, then go to DONE if length=0, else DATA_RD.
REQ-015 DATA_RD SHALL assert rd_en for 1 cycle with addr = pointer, then go to DATA_WAIT.
REQ-016 DATA_WAIT SHALL load o_rfa_tx_data from i_rfa_regf_data_rd, then go to TX_HOLD.
REQ-017 In TX_HOLD, o_rfa_tx_valid SHALL be 1 and o_rfa_tx_data SHALL be stable until i_rfa_tx_ready=1.
REQ-018 On a TX handshake the block SHALL increment pointer and count, decrement remaining, then go to DONE if remaining reaches 0, else DATA_RD.
REQ-019 In RX_WAIT, o_rfa_rx_ready SHALL be 1; on i_rfa_rx_valid=1 the block SHALL capture i_rfa_rx_data and go to WR.
REQ-020 WR SHALL assert wr_en for 1 cycle with addr = pointer and data_wr = the captured byte, update pointer, count and remaining, then go to DONE if remaining reaches 0, else RX_WAIT.
REQ-021 DONE SHALL pulse o_rfa_done for 1 cycle, then go to IDLE.
REQ-022 rd_en and wr_en SHALL never be 1 in the same cycle, and each SHALL be high for at most 1 consecutive cycle.
REQ-023 o_rfa_regf_addr SHALL hold its last value when neither enable is asserted.
REQ-024 Pointer arithmetic SHALL be modulo 2^ADDR (address 2^ADDR-1 wraps to 0), including base+1 in LEN_WAIT.
REQ-025 Length and count SHALL be WIDTH bits, so the maximum burst is 2^WIDTH-1 bytes.
REQ-026 o_rfa_busy SHALL be 1 in every state except IDLE.
REQ-027 i_rfa_start SHALL be ignored when not in IDLE.
REQ-028 i_rfa_abort in any non-IDLE state except DONE SHALL move the FSM to IDLE next cycle with a 1-cycle o_rfa_abort_ack, no o_rfa_done, and all enables and valids deasserted.
REQ-029 i_rfa_abort SHALL be ignored in IDLE and in DONE.
REQ-030 Abort coincident with an RX handshake SHALL discard the byte with no write.
REQ-031 Abort coincident with a TX handshake SHALL count the byte as transferred (count incremented).
REQ-032 Abort coincident with WR SHALL take priority, suppressing wr_en in that cycle.
REQ-033 Abort SHALL leave o_rfa_count holding the bytes completed.
REQ-034 o_rfa_rx_ready SHALL be 0 outside RX_WAIT, and o_rfa_tx_valid SHALL be 0 outside TX_HOLD.

Reset
REQ-035 While i_rfa_rst=1 at a clock edge, the FSM SHALL enter IDLE and all outputs, the pointer, length and count SHALL be 0.
REQ-036 Reset SHALL override start and abort, and reset mid-burst SHALL abandon the burst with no done and no abort_ack.

Verification
REQ-037 Read burst: reg[1]=2, reg[2]=0x01, reg[3]=0x02, start dir=0 base=1, tx_ready=1 -> rd_en at addr 1, 2, 3, TX bytes 0x01 then 0x02, done pulse, count=2.
REQ-038 TX back-pressure: tx_ready=0 for 5 cycles in TX_HOLD -> valid held and data stable, no new rd_en, and the burst completes once ready=1.
REQ-039 Write burst: dir=1, base=5, len=3, RX bytes 0xA1, 0xA2, 0xA3 with gaps -> wr_en pulses at addr 5, 6, 7 with matching data, done pulse, count=3.
REQ-040 Wrap and zero length: dir=1, base=1023, len=2 -> writes at 1023 then 0; separately, read with reg[base]=0 -> a single rd_en, then done with count=0.
REQ-041 Abort: dir=1, len=4, abort after 2 writes, coincident with rx_valid -> no third write, abort_ack pulse, no done, count=2, busy=0 next cycle.
REQ-042 Reset mid-burst: rst=1 during TX_HOLD -> all outputs 0 next cycle, and a subsequent start behaves as from a fresh reset.
